// File: rtl/cp0_irq_ctrl.sv
// -----------------------------------------------------------------------------
// cp0_irq_ctrl
//
// Coprocessor-0 interrupt/exception controller. It holds the SR, Cause, EPC and
// PRId registers. It samples the device IRQ lines HWInt[7:2] into Cause.IP and
// tells the pipeline when to take an exception.
//
// Optional build macro:
//   IP_STICKY_EN  When defined, the IP bits latch any HWInt pulse. They hold until
//                 an mtc0 to Cause clears them (a 0 in WD clears that bit).
//                 When undefined, IP mirrors HWInt each cycle and mtc0 Cause has
//                 no effect.
//
// Ports:
//   CLK      in   1   clock; all state updates on its rising edge
//   RST      in   1   synchronous active-high reset
//   ADDR     in   5   CP0 register select (12 SR, 13 Cause, 14 EPC, 15 PRId)
//   WE       in   1   mtc0 write strobe
//   WD       in   32  mtc0 write data
//   RD       out  32  mfc0 read data (combinational; unmapped -> 0)
//   PC       in   32  commit-stage PC (word aligned)
//   BD       in   1   commit-stage instruction is in a branch delay slot
//   ExcIn    in   5   synchronous exception code (0 = none)
//   HWInt    in   6   device interrupt lines
//   EXLSet   in   1   pipeline takes the exception this cycle
//   EXLClr   in   1   eret commits this cycle
//   ExcReq   out  1   exception request (combinational)
//   EPC_out  out  32  current EPC (eret target)
// -----------------------------------------------------------------------------
module cp0_irq_ctrl #(
   parameter logic [31:0] PRID_VAL  = 32'h0000_4B38,
   parameter int          NUM_HWINT = 6
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [4:0]           ADDR,
   input  logic                 WE,
   input  logic [31:0]          WD,
   output logic [31:0]          RD,
   input  logic [31:0]          PC,
   input  logic                 BD,
   input  logic [4:0]           ExcIn,
   input  logic [NUM_HWINT-1:0] HWInt,
   input  logic                 EXLSet,
   input  logic                 EXLClr,
   output logic                 ExcReq,
   output logic [31:0]          EPC_out
);

   localparam logic [4:0] ADDR_SR    = 5'd12;
   localparam logic [4:0] ADDR_CAUSE = 5'd13;
   localparam logic [4:0] ADDR_EPC   = 5'd14;
   localparam logic [4:0] ADDR_PRID  = 5'd15;

   // Architectural state: only the implemented fields are stored
   logic [NUM_HWINT-1:0] im_reg;
   logic                 exl_reg;
   logic                 ie_reg;
   logic                 bd_reg;
   logic [NUM_HWINT-1:0] ip_reg;
   logic [NUM_HWINT-1:0] ip_next;
   logic [4:0]           exc_code_reg;
   logic [31:2]          epc_reg;

   logic                 int_pend;
   logic [31:2]          epc_entry;
   logic                 sr_wr;
   logic                 epc_wr;
   logic                 pc_unused;

   // PC is word aligned, so only the word address takes part in EPC. The
   // delay-slot subtraction wraps modulo 2^32 (PC=0 gives 0xFFFF_FFFC).
   assign epc_entry = BD ? (PC[31:2] - 30'd1) : PC[31:2];
   assign pc_unused = &{1'b0, PC[1:0]};

   assign int_pend = (|(ip_reg & im_reg)) & ie_reg & ~exl_reg;
   assign ExcReq   = ~exl_reg & (int_pend | (ExcIn != 5'd0));
   assign EPC_out  = {epc_reg, 2'b00};

   // Exception entry discards any mtc0 in the same cycle
   assign sr_wr  = WE & (ADDR == ADDR_SR)  & ~EXLSet;
   assign epc_wr = WE & (ADDR == ADDR_EPC) & ~EXLSet;

   // Per-line IP capture
`ifdef IP_STICKY_EN
   logic cause_wr;
   assign cause_wr = WE & (ADDR == ADDR_CAUSE) & ~EXLSet;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < NUM_HWINT; gi++) begin : g_ip
`ifdef IP_STICKY_EN
         // When a set and a clear arrive in the same cycle, the set wins, so
         // the new pulse is not lost.
         assign ip_next[gi] = HWInt[gi] | (ip_reg[gi] & ~(cause_wr & ~WD[10+gi]));
`else
         assign ip_next[gi] = HWInt[gi];
`endif
         always_ff @(posedge CLK) begin
            if (RST) begin
               ip_reg[gi] <= 1'b0;
            end else begin
               ip_reg[gi] <= ip_next[gi];
            end
         end
      end
   endgenerate

   // SR / Cause(BD, ExcCode) / EPC
   always_ff @(posedge CLK) begin
      if (RST) begin
         im_reg       <= '0;
         exl_reg      <= 1'b0;
         ie_reg       <= 1'b0;
         bd_reg       <= 1'b0;
         exc_code_reg <= 5'd0;
         epc_reg      <= '0;
      end else if (EXLSet) begin
         // Exception entry overrides eret and mtc0 in the same cycle
         exl_reg      <= 1'b1;
         bd_reg       <= BD;
         epc_reg      <= epc_entry;
         exc_code_reg <= int_pend ? 5'd0 : ExcIn;
      end else begin
         if (sr_wr) begin
            im_reg  <= WD[10 +: NUM_HWINT];
            ie_reg  <= WD[0];
            exl_reg <= WD[1];
         end
         // eret beats an SR write on EXL only; IM/IE still take WD above
         if (EXLClr) begin
            exl_reg <= 1'b0;
         end
         if (epc_wr) begin
            epc_reg <= WD[31:2];
         end
      end
   end

   // mfc0 read mux
   always_comb begin
      RD = 32'd0;
      case (ADDR)
         ADDR_SR:    RD = {16'd0, im_reg, 8'd0, exl_reg, ie_reg};
         ADDR_CAUSE: RD = {bd_reg, 15'd0, ip_reg, 3'd0, exc_code_reg, 2'd0};
         ADDR_EPC:   RD = {epc_reg, 2'b00};
         ADDR_PRID:  RD = PRID_VAL;
         default:    RD = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cp0_irq_ctrl
//
// Self-checking bench for cp0_irq_ctrl. It has three parts:
//   - a table of one-cycle vectors, with the state read back after each edge
//   - a short hand-written sequence for the pulse/IP capture behaviour, which
//     depends on IP_STICKY_EN
//   - randomized traffic compared against a word-level reference model
// -----------------------------------------------------------------------------
module tb_cp0_irq_ctrl;

   localparam logic [31:0] PRID = 32'h0000_4B38;

   logic        CLK;
   logic        RST;
   logic [4:0]  ADDR;
   logic        WE;
   logic [31:0] WD;
   logic [31:0] RD;
   logic [31:0] PC;
   logic        BD;
   logic [4:0]  ExcIn;
   logic [5:0]  HWInt;
   logic        EXLSet;
   logic        EXLClr;
   logic        ExcReq;
   logic [31:0] EPC_out;

   int checks   = 0;
   int failures = 0;

   cp0_irq_ctrl #(.PRID_VAL(PRID), .NUM_HWINT(6)) dut (
      .CLK(CLK), .RST(RST), .ADDR(ADDR), .WE(WE), .WD(WD), .RD(RD),
      .PC(PC), .BD(BD), .ExcIn(ExcIn), .HWInt(HWInt),
      .EXLSet(EXLSet), .EXLClr(EXLClr), .ExcReq(ExcReq), .EPC_out(EPC_out)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // Apply one cycle of inputs, clock it, then drop the strobes and select raddr
   task automatic drive(input logic rst, input logic we, input logic [4:0] addr,
                        input logic [31:0] wd, input logic [31:0] pc, input logic bd,
                        input logic [4:0] exc, input logic [5:0] hw,
                        input logic set, input logic clr, input logic [4:0] raddr);
      RST = rst; WE = we; ADDR = addr; WD = wd; PC = pc; BD = bd;
      ExcIn = exc; HWInt = hw; EXLSet = set; EXLClr = clr;
      @(posedge CLK);
      #1;
      RST = 1'b0; WE = 1'b0; EXLSet = 1'b0; EXLClr = 1'b0; ExcIn = 5'd0;
      ADDR = raddr;
      #1;
   endtask

   // ---------------------------------------------------------------- vectors
   typedef struct {
      logic        rst;
      logic        we;
      logic [4:0]  addr;
      logic [31:0] wd;
      logic [31:0] pc;
      logic        bd;
      logic [4:0]  exc;
      logic [5:0]  hw;
      logic        set;
      logic        clr;
      logic [4:0]  raddr;
      logic [31:0] exp_rd;
      logic        exp_req;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic rst, logic we, logic [4:0] addr, logic [31:0] wd,
                               logic [31:0] pc, logic bd, logic [4:0] exc, logic [5:0] hw,
                               logic set, logic clr, logic [4:0] raddr,
                               logic [31:0] exp_rd, logic exp_req);
      vec_t v;
      v.rst = rst; v.we = we; v.addr = addr; v.wd = wd; v.pc = pc; v.bd = bd;
      v.exc = exc; v.hw = hw; v.set = set; v.clr = clr; v.raddr = raddr;
      v.exp_rd = exp_rd; v.exp_req = exp_req;
      return v;
   endfunction

   // ---------------------------------------------------------------- model
   logic [31:0] m_sr, m_cause, m_epc;
   logic [31:0] n_sr, n_cause, n_epc;

   function automatic logic m_intpend();
      logic [5:0] ip;
      logic [5:0] im;
      ip = m_cause[15:10];
      im = m_sr[15:10];
      return ((ip & im) != 6'd0) && m_sr[0] && !m_sr[1];
   endfunction

   function automatic logic [31:0] m_read(logic [4:0] a);
      case (a)
         5'd12:   return m_sr;
         5'd13:   return m_cause;
         5'd14:   return m_epc;
         5'd15:   return PRID;
         default: return 32'd0;
      endcase
   endfunction

   // Next architectural state from the current inputs, as whole register words
   task automatic m_next();
      logic [5:0] new_ip;
      logic       ipend;
      ipend = m_intpend();
      if (RST) begin
         n_sr = 32'd0; n_cause = 32'd0; n_epc = 32'd0;
      end else begin
         n_sr = m_sr; n_cause = m_cause; n_epc = m_epc;
`ifdef IP_STICKY_EN
         new_ip = m_cause[15:10] | HWInt;
         if (WE && ADDR == 5'd13 && !EXLSet)
            new_ip = (m_cause[15:10] & WD[15:10]) | HWInt;
`else
         new_ip = HWInt;
`endif
         if (EXLSet) begin
            n_sr[1]      = 1'b1;
            n_cause[31]  = BD;
            n_cause[6:2] = ipend ? 5'd0 : ExcIn;
            n_epc        = (BD ? PC - 32'd4 : PC) & 32'hFFFF_FFFC;
         end else begin
            if (WE && ADDR == 5'd12) n_sr = WD & 32'h0000_FC03;
            if (EXLClr)              n_sr[1] = 1'b0;
            if (WE && ADDR == 5'd14) n_epc = WD & 32'hFFFF_FFFC;
         end
         n_cause[15:10] = new_ip;
      end
   endtask

   // ---------------------------------------------------------------- test
   initial begin
      RST = 1'b1; WE = 1'b0; ADDR = 5'd0; WD = 32'd0; PC = 32'd0; BD = 1'b0;
      ExcIn = 5'd0; HWInt = 6'd0; EXLSet = 1'b0; EXLClr = 1'b0;
      m_sr = 32'd0; m_cause = 32'd0; m_epc = 32'd0;
      n_sr = 32'd0; n_cause = 32'd0; n_epc = 32'd0;

      //             rst we addr  wd             pc             bd exc  hw  set clr raddr expected-rd    req
      vecs.push_back(mk(1, 0, 5'd0, 32'd0,        32'd0,         0, 5'd0, 6'd0, 0, 0, 5'd12, 32'd0,        0));
      vecs.push_back(mk(1, 0, 5'd0, 32'd0,        32'd0,         0, 5'd0, 6'd0, 0, 0, 5'd13, 32'd0,        0));
      vecs.push_back(mk(0, 0, 5'd0, 32'd0,        32'd0,         0, 5'd0, 6'd0, 0, 0, 5'd14, 32'd0,        0));
      vecs.push_back(mk(0, 0, 5'd0, 32'd0,        32'd0,         0, 5'd0, 6'd0, 0, 0, 5'd15, PRID,         0));
      // basic interrupt entry
      vecs.push_back(mk(0, 1, 5'd12, 32'h401,     32'd0,         0, 5'd0, 6'd0, 0, 0, 5'd12, 32'h401,      0));
      vecs.push_back(mk(0, 0, 5'd0, 32'd0,        32'd0,         0, 5'd0, 6'd1, 0, 0, 5'd13, 32'h400,      1));
      vecs.push_back(mk(0, 0, 5'd0, 32'd0,        32'h3010,      0, 5'd0, 6'd1, 1, 0, 5'd14, 32'h3010,     0));
      vecs.push_back(mk(0, 0, 5'd0, 32'd0,        32'd0,         0, 5'd0, 6'd1, 0, 0, 5'd12, 32'h403,      0));
      vecs.push_back(mk(0, 0, 5'd0, 32'd0,        32'd0,         0, 5'd0, 6'd1, 0, 0, 5'd13, 32'h400,      0));
      // eret with IP still pending -> re-entry request
      vecs.push_back(mk(0, 0, 5'd0, 32'd0,        32'd0,         0, 5'd0, 6'd1, 0, 1, 5'd12, 32'h401,      1));
      // mask interrupts, clear IP, then delay-slot exception
      vecs.push_back(mk(0, 1, 5'd12, 32'h1,       32'd0,         0, 5'd0, 6'd0, 0, 0, 5'd12, 32'h1,        0));
      vecs.push_back(mk(0, 1, 5'd13, 32'd0,       32'd0,         0, 5'd0, 6'd0, 0, 0, 5'd12, 32'h1,        0));
      vecs.push_back(mk(0, 0, 5'd0, 32'd0,        32'h3008,      1, 5'd4, 6'd0, 1, 0, 5'd14, 32'h3004,     0));
      vecs.push_back(mk(0, 0, 5'd0, 32'd0,        32'd0,         0, 5'd0, 6'd0, 0, 0, 5'd13, 32'h8000_0010,0));
      vecs.push_back(mk(0, 0, 5'd0, 32'd0,        32'd0,         0, 5'd0, 6'd0, 0, 1, 5'd12, 32'h1,        0));
      // interrupt has priority over ExcIn
      vecs.push_back(mk(0, 1, 5'd12, 32'h401,     32'd0,         0, 5'd0, 6'd1, 0, 0, 5'd12, 32'h401,      1));
      vecs.push_back(mk(0, 0, 5'd0, 32'd0,        32'h3008,      1, 5'd4, 6'd1, 1, 0, 5'd13, 32'h8000_0400,0));
      vecs.push_back(mk(0, 1, 5'd13, 32'd0,       32'd0,         0, 5'd0, 6'd0, 0, 1, 5'd12, 32'h401,      0));
      // EXLSet + EXLClr + mtc0 EPC in one cycle
      vecs.push_back(mk(0, 1, 5'd14, 32'h1234,    32'h3020,      0, 5'd0, 6'd0, 1, 1, 5'd14, 32'h3020,     0));
      vecs.push_back(mk(0, 0, 5'd0, 32'd0,        32'd0,         0, 5'd0, 6'd0, 0, 0, 5'd12, 32'h403,      0));
      // PC-4 wrap
      vecs.push_back(mk(0, 0, 5'd0, 32'd0,        32'd0,         0, 5'd0, 6'd0, 0, 1, 5'd12, 32'h401,      0));
      vecs.push_back(mk(0, 0, 5'd0, 32'd0,        32'd0,         1, 5'd8, 6'd0, 1, 0, 5'd14, 32'hFFFF_FFFC,0));
      vecs.push_back(mk(0, 0, 5'd0, 32'd0,        32'd0,         0, 5'd0, 6'd0, 0, 0, 5'd13, 32'h8000_0020,0));
      // eret together with SR write: EXL clears, IM/IE from WD
      vecs.push_back(mk(0, 1, 5'd12, 32'hFFFF_FFFF,32'd0,        0, 5'd0, 6'd0, 0, 1, 5'd12, 32'h0000_FC01,0));
      vecs.push_back(mk(0, 0, 5'd0, 32'd0,        32'd0,         0, 5'd0, 6'd0, 0, 0, 5'd3,  32'd0,        0));
      vecs.push_back(mk(0, 1, 5'd15, 32'hDEAD,    32'd0,         0, 5'd0, 6'd0, 0, 0, 5'd15, PRID,         0));
      vecs.push_back(mk(0, 1, 5'd14, 32'h1237,    32'd0,         0, 5'd0, 6'd0, 0, 0, 5'd14, 32'h1234,     0));
      // reset in the middle of a handler with an IRQ pending
      vecs.push_back(mk(0, 0, 5'd0, 32'd0,        32'h40,        0, 5'd2, 6'd0, 1, 0, 5'd12, 32'hFC03,     0));
      vecs.push_back(mk(1, 0, 5'd0, 32'd0,        32'd0,         0, 5'd0, 6'd1, 0, 0, 5'd13, 32'd0,        0));
      vecs.push_back(mk(0, 0, 5'd0, 32'd0,        32'd0,         0, 5'd0, 6'd0, 0, 0, 5'd12, 32'd0,        0));

      @(posedge CLK);
      #1;
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst, vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].pc, vecs[i].bd,
               vecs[i].exc, vecs[i].hw, vecs[i].set, vecs[i].clr, vecs[i].raddr);
         $display("vec %0d: ADDR=%0d RD=%08h ExcReq=%0b", i, ADDR, RD, ExcReq);
         chk($sformatf("vec%0d_rd", i), RD, vecs[i].exp_rd);
         chk($sformatf("vec%0d_excreq", i), {31'd0, ExcReq}, {31'd0, vecs[i].exp_req});
      end

      // ------------------------------------------ pulse while in handler
      drive(1, 0, 5'd0, 32'd0, 32'd0, 0, 5'd0, 6'd0, 0, 0, 5'd12);
      drive(0, 1, 5'd12, 32'h401, 32'd0, 0, 5'd0, 6'd0, 0, 0, 5'd12);
      drive(0, 0, 5'd0, 32'd0, 32'h100, 0, 5'd1, 6'd0, 1, 0, 5'd12);
      chk("seq_exl_set", RD, 32'h403);
      drive(0, 0, 5'd0, 32'd0, 32'd0, 0, 5'd0, 6'd1, 0, 0, 5'd13);
      drive(0, 0, 5'd0, 32'd0, 32'd0, 0, 5'd0, 6'd0, 0, 0, 5'd13);
`ifdef IP_STICKY_EN
      chk("seq_pulse_cause", RD, 32'h404);
`else
      chk("seq_pulse_cause", RD, 32'h004);
`endif
      chk("seq_pulse_noreq", {31'd0, ExcReq}, 32'd0);
      drive(0, 0, 5'd0, 32'd0, 32'd0, 0, 5'd0, 6'd0, 0, 1, 5'd13);
`ifdef IP_STICKY_EN
      chk("seq_eret_req", {31'd0, ExcReq}, 32'd1);
`else
      chk("seq_eret_req", {31'd0, ExcReq}, 32'd0);
`endif
      drive(0, 1, 5'd13, 32'd0, 32'd0, 0, 5'd0, 6'd0, 0, 0, 5'd13);
      chk("seq_cause_clear", RD, 32'h004);
      chk("seq_clear_noreq", {31'd0, ExcReq}, 32'd0);
      $display("sequence: pulse/eret/clear done, Cause=%08h", RD);

      // ------------------------------------------ random vs model
      for (int n = 0; n < 3000; n++) begin
         RST = (n == 0) || ($urandom_range(0, 63) == 0);
         WE  = ($urandom_range(0, 3) == 0);
         case ($urandom_range(0, 5))
            0:       ADDR = 5'd12;
            1:       ADDR = 5'd13;
            2:       ADDR = 5'd14;
            3:       ADDR = 5'd15;
            default: ADDR = 5'($urandom_range(0, 31));
         endcase
         WD     = $urandom;
         PC     = $urandom & 32'hFFFF_FFFC;
         BD     = 1'($urandom_range(0, 1));
         ExcIn  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
         HWInt  = 6'($urandom) & 6'($urandom);
         EXLSet = ($urandom_range(0, 5) == 0);
         EXLClr = ($urandom_range(0, 5) == 0);
         #1;
         if (n > 0) begin
            chk($sformatf("rnd%0d_rd", n), RD, m_read(ADDR));
            chk($sformatf("rnd%0d_epc", n), EPC_out, m_epc);
            chk($sformatf("rnd%0d_excreq", n), {31'd0, ExcReq},
                {31'd0, (!m_sr[1] && (m_intpend() || ExcIn != 5'd0))});
         end
         m_next();
         @(posedge CLK);
         #1;
         m_sr = n_sr; m_cause = n_cause; m_epc = n_epc;
      end
      $display("random: 3000 cycles compared against model");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
